// File: rtl/decode_ctrl_stage.sv
// Registered RV32I control decoder: decodes one instruction into control bits and
// holds it in a single valid/ready entry. Optional M-extension MUL decode under DECODE_MEXT_EN.
module decode_ctrl_stage #(
    parameter int ALU_OP_W  = 4,
    parameter int ILL_CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [31:0]          in_instr,
    input  logic                 flush,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic                 out_alu_src,
    output logic                 out_mem_to_reg,
    output logic                 out_reg_write,
    output logic                 out_mem_read,
    output logic                 out_mem_write,
    output logic                 out_branch,
    output logic [ALU_OP_W-1:0]  out_alu_op,
    output logic [4:0]           out_rd,
    output logic [4:0]           out_rs1,
    output logic [4:0]           out_rs2,
    output logic                 out_illegal,
    output logic [ILL_CNT_W-1:0] ill_count
);
    localparam logic [ALU_OP_W-1:0] OP_ADD  = ALU_OP_W'(0);
    localparam logic [ALU_OP_W-1:0] OP_SUB  = ALU_OP_W'(1);
    localparam logic [ALU_OP_W-1:0] OP_AND  = ALU_OP_W'(2);
    localparam logic [ALU_OP_W-1:0] OP_OR   = ALU_OP_W'(3);
    localparam logic [ALU_OP_W-1:0] OP_XOR  = ALU_OP_W'(4);
    localparam logic [ALU_OP_W-1:0] OP_SLL  = ALU_OP_W'(5);
    localparam logic [ALU_OP_W-1:0] OP_SRL  = ALU_OP_W'(6);
    localparam logic [ALU_OP_W-1:0] OP_SRA  = ALU_OP_W'(7);
    localparam logic [ALU_OP_W-1:0] OP_SLT  = ALU_OP_W'(8);
    localparam logic [ALU_OP_W-1:0] OP_SLTU = ALU_OP_W'(9);
`ifdef DECODE_MEXT_EN
    localparam logic [ALU_OP_W-1:0] OP_MUL  = ALU_OP_W'(10);
`endif
    localparam logic [ALU_OP_W-1:0] OP_INV  = '1;

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       d_src, d_m2r, d_rw, d_mr, d_mw, d_br, d_ill;
    logic [ALU_OP_W-1:0] d_op;
    logic       capture;

    assign opc = in_instr[6:0];
    assign f3  = in_instr[14:12];
    assign f7  = in_instr[31:25];

    always_comb begin
        d_src = 1'b0;
        d_m2r = 1'b0;
        d_rw  = 1'b0;
        d_mr  = 1'b0;
        d_mw  = 1'b0;
        d_br  = 1'b0;
        d_ill = 1'b0;
        d_op  = OP_ADD;
        case (opc)
            7'b0110011: begin
                d_rw = 1'b1;
                case ({f7, f3})
                    10'b0000000_000: d_op = OP_ADD;
                    10'b0100000_000: d_op = OP_SUB;
                    10'b0000000_111: d_op = OP_AND;
                    10'b0000000_110: d_op = OP_OR;
                    10'b0000000_100: d_op = OP_XOR;
                    10'b0000000_001: d_op = OP_SLL;
                    10'b0000000_101: d_op = OP_SRL;
                    10'b0100000_101: d_op = OP_SRA;
                    10'b0000000_010: d_op = OP_SLT;
                    10'b0000000_011: d_op = OP_SLTU;
`ifdef DECODE_MEXT_EN
                    10'b0000001_000: d_op = OP_MUL;
`endif
                    default:         d_ill = 1'b1;
                endcase
            end
            7'b0010011: begin
                d_src = 1'b1;
                d_rw  = 1'b1;
                case (f3)
                    3'b000: d_op = OP_ADD;
                    3'b100: d_op = OP_XOR;
                    3'b110: d_op = OP_OR;
                    3'b111: d_op = OP_AND;
                    3'b010: d_op = OP_SLT;
                    3'b011: d_op = OP_SLTU;
                    3'b001: begin
                        d_op  = OP_SLL;
                        d_ill = (f7 != 7'b0000000);
                    end
                    default: begin
                        // f3 == 101: the funct7 field picks logical vs arithmetic shift
                        if (f7 == 7'b0000000)      d_op = OP_SRL;
                        else if (f7 == 7'b0100000) d_op = OP_SRA;
                        else                       d_ill = 1'b1;
                    end
                endcase
            end
            7'b0000011: begin
                d_src = 1'b1;
                d_mr  = 1'b1;
                d_m2r = 1'b1;
                d_rw  = 1'b1;
                d_ill = (f3 != 3'b010);
            end
            7'b0100011: begin
                d_src = 1'b1;
                d_mw  = 1'b1;
                d_ill = (f3 != 3'b010);
            end
            7'b1100011: begin
                d_br  = 1'b1;
                d_op  = OP_SUB;
                d_ill = (f3 != 3'b000) && (f3 != 3'b001);
            end
            default: d_ill = 1'b1;
        endcase
        if (d_ill) begin
            d_src = 1'b0;
            d_m2r = 1'b0;
            d_rw  = 1'b0;
            d_mr  = 1'b0;
            d_mw  = 1'b0;
            d_br  = 1'b0;
            d_op  = OP_INV;
        end else if (in_instr[11:7] == 5'd0) begin
            d_rw = 1'b0;
        end
    end

    // Valid/ready: a transfer happens on an edge where valid and ready are both high;
    // flush blocks acceptance and drops the held entry.
    assign in_ready = !rst && !flush && (!out_valid || out_ready);
    assign capture  = in_valid && in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid      <= 1'b0;
            out_alu_src    <= 1'b0;
            out_mem_to_reg <= 1'b0;
            out_reg_write  <= 1'b0;
            out_mem_read   <= 1'b0;
            out_mem_write  <= 1'b0;
            out_branch     <= 1'b0;
            out_alu_op     <= '0;
            out_rd         <= '0;
            out_rs1        <= '0;
            out_rs2        <= '0;
            out_illegal    <= 1'b0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (capture) begin
            out_valid      <= 1'b1;
            out_alu_src    <= d_src;
            out_mem_to_reg <= d_m2r;
            out_reg_write  <= d_rw;
            out_mem_read   <= d_mr;
            out_mem_write  <= d_mw;
            out_branch     <= d_br;
            out_alu_op     <= d_op;
            out_rd         <= in_instr[11:7];
            out_rs1        <= in_instr[19:15];
            out_rs2        <= in_instr[24:20];
            out_illegal    <= d_ill;
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ill_count <= '0;
        end else if (capture && d_ill && (ill_count != '1)) begin
            ill_count <= ill_count + ILL_CNT_W'(1);
        end
    end
endmodule
